// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini-SRC style datapath: ALU opcodes, strobe and
// bus-driver bit positions, and instruction-register field positions.
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHR  = 5'd4,
        OP_SHRA = 5'd5,
        OP_SHL  = 5'd6,
        OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,
        OP_MUL  = 5'd9,
        OP_DIV  = 5'd10,
        OP_NEG  = 5'd11,
        OP_NOT  = 5'd12,
        OP_INC  = 5'd13
    } alu_op_e;

    // Bit positions inside the enable (load strobe) vector
    localparam int EN_PC     = 0;
    localparam int EN_IR     = 1;
    localparam int EN_MAR    = 2;
    localparam int EN_MDR    = 3;
    localparam int EN_Y      = 4;
    localparam int EN_Z      = 5;
    localparam int EN_HI     = 6;
    localparam int EN_LO     = 7;
    localparam int EN_INPORT = 8;
    localparam int EN_CON    = 9;

    // Bit positions inside the busSelect (bus driver) vector
    localparam int BS_PC     = 0;
    localparam int BS_MDR    = 1;
    localparam int BS_ZHI    = 2;
    localparam int BS_ZLO    = 3;
    localparam int BS_HI     = 4;
    localparam int BS_LO     = 5;
    localparam int BS_INPORT = 6;
    localparam int BS_C      = 7;

    // Instruction register fields
    localparam int IR_RA_HI   = 26;
    localparam int IR_RA_LO   = 23;
    localparam int IR_RB_HI   = 22;
    localparam int IR_RB_LO   = 19;
    localparam int IR_RC_HI   = 18;
    localparam int IR_RC_LO   = 15;
    localparam int IR_COND_HI = 20;
    localparam int IR_COND_LO = 19;
    localparam int IR_C_HI    = 18;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A comes from Y, B from the bus. Result is 64 bits so MUL
// and DIV can return their upper halves; every other op leaves the top zero.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [4:0]          op,
    output logic [2*DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]            amt;
    logic [2*DATA_W-1:0]        dbl_r;
    logic [2*DATA_W-1:0]        dbl_l;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] product;
    logic signed [DATA_W-1:0]   quot;
    logic signed [DATA_W-1:0]   rem;

    assign amt     = b[SH_W-1:0];
    // Rotates come from shifting a doubled copy of A
    assign dbl_r   = {a, a} >> amt;
    assign dbl_l   = {a, a} << amt;
    assign a_ext   = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext   = {{DATA_W{b[DATA_W-1]}}, b};
    assign product = a_ext * b_ext;

    // Zero divisor yields all-ones quotient and A as remainder; a divisor of
    // -1 is handled apart so the most-negative dividend never overflows.
    always_comb begin
        quot = '1;
        rem  = $signed(a);
        if (b == '1) begin
            quot = -$signed(a);
            rem  = '0;
        end else if (b != '0) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        result = {{DATA_W{1'b0}}, b};
        case (op)
            OP_ADD:  result[DATA_W-1:0] = a + b;
            OP_SUB:  result[DATA_W-1:0] = a - b;
            OP_AND:  result[DATA_W-1:0] = a & b;
            OP_OR:   result[DATA_W-1:0] = a | b;
            OP_SHR:  result[DATA_W-1:0] = a >> amt;
            OP_SHRA: result[DATA_W-1:0] = $signed(a) >>> amt;
            OP_SHL:  result[DATA_W-1:0] = a << amt;
            OP_ROR:  result[DATA_W-1:0] = dbl_r[DATA_W-1:0];
            OP_ROL:  result[DATA_W-1:0] = dbl_l[2*DATA_W-1:DATA_W];
            OP_MUL:  result = product;
            OP_DIV:  result = {rem, quot};
            OP_NEG:  result[DATA_W-1:0] = -b;
            OP_NOT:  result[DATA_W-1:0] = ~b;
            OP_INC:  result[DATA_W-1:0] = b + DATA_W'(1);
            default: result = {{DATA_W{1'b0}}, b};
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux, ALU and
// word RAM, all sequenced by an external control unit one cycle at a time.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 512
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              MD_Read,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    input  logic              WriteRAM,
    input  logic              ReadRAM,
    input  logic [31:0]       enable,
    input  logic [31:0]       busSelect,
    input  logic [DATA_W-1:0] InPortData,
    input  logic [4:0]        Control_Signals,
    output logic [DATA_W-1:0] ir,
    output logic              CONFFOut,
    input  logic              Stop
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0]   gpr [16];
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   mar;
    logic [DATA_W-1:0]   mdr;
    logic [DATA_W-1:0]   y;
    logic [2*DATA_W-1:0] z;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   in_port;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   ram_data;
    logic [DATA_W-1:0]   mdr_next;
    logic [DATA_W-1:0]   c_sext;
    logic [2*DATA_W-1:0] alu_result;
    logic [3:0]          reg_idx;
    logic [ADDR_W-1:0]   ram_addr;
    logic                con_next;
    logic                wr_ok;
    logic                unused_bits;

    assign wr_ok       = !Reset && !Stop;
    assign ram_addr    = mar[ADDR_W-1:0];
    assign c_sext      = {{(DATA_W-IR_C_HI-1){ir[IR_C_HI]}}, ir[IR_C_HI:0]};
    assign unused_bits = ^{enable[31:10], busSelect[31:8], mar[DATA_W-1:ADDR_W]};

    always_comb begin
        reg_idx = 4'd0;
        if (Gra)      reg_idx = ir[IR_RA_HI:IR_RA_LO];
        else if (Grb) reg_idx = ir[IR_RB_HI:IR_RB_LO];
        else if (Grc) reg_idx = ir[IR_RC_HI:IR_RC_LO];
    end

    // Priority bus mux; an undriven bus reads as zero
    always_comb begin
        bus = '0;
        if (Rout)                      bus = gpr[reg_idx];
        else if (BAout)                bus = (reg_idx == 4'd0) ? '0 : gpr[reg_idx];
        else if (busSelect[BS_PC])     bus = pc;
        else if (busSelect[BS_MDR])    bus = mdr;
        else if (busSelect[BS_ZHI])    bus = z[2*DATA_W-1:DATA_W];
        else if (busSelect[BS_ZLO])    bus = z[DATA_W-1:0];
        else if (busSelect[BS_HI])     bus = hi;
        else if (busSelect[BS_LO])     bus = lo;
        else if (busSelect[BS_INPORT]) bus = in_port;
        else if (busSelect[BS_C])      bus = c_sext;
    end

    always_comb begin
        con_next = 1'b0;
        case (ir[IR_COND_HI:IR_COND_LO])
            2'b00: con_next = (bus == '0);
            2'b01: con_next = (bus != '0);
            2'b10: con_next = !bus[DATA_W-1];
            2'b11: con_next = bus[DATA_W-1];
            default: con_next = 1'b0;
        endcase
    end

    assign ram_data = ReadRAM ? mem[ram_addr] : '0;
    assign mdr_next = MD_Read ? ram_data : bus;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (y),
        .b      (bus),
        .op     (Control_Signals),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            z        <= '0;
            hi       <= '0;
            lo       <= '0;
            in_port  <= '0;
            CONFFOut <= 1'b0;
        end else if (!Stop) begin
            if (Rin)               gpr[reg_idx] <= bus;
            if (enable[EN_PC])     pc           <= bus;
            if (enable[EN_IR])     ir           <= bus;
            if (enable[EN_MAR])    mar          <= bus;
            if (enable[EN_MDR])    mdr          <= mdr_next;
            if (enable[EN_Y])      y            <= bus;
            if (enable[EN_Z])      z            <= alu_result;
            if (enable[EN_HI])     hi           <= bus;
            if (enable[EN_LO])     lo           <= bus;
            if (enable[EN_INPORT]) in_port      <= InPortData;
            if (enable[EN_CON])    CONFFOut     <= con_next;
        end
    end

    // RAM is never cleared; reads above see the word from before this edge
    always_ff @(posedge clk) begin
        if (wr_ok && WriteRAM) mem[ram_addr] <= mdr;
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: drivers queue expected values, a monitor on
// the falling edge pops them and compares against the observed datapath state.
module tb_cpu_datapath;
    import cpu_pkg::*;

    localparam int S_BUS = 0;
    localparam int S_IR  = 1;
    localparam int S_CON = 2;
    localparam int S_PC  = 3;
    localparam int S_MAR = 4;
    localparam int S_MDR = 5;
    localparam int S_Y   = 6;
    localparam int S_Z   = 7;
    localparam int S_HI  = 8;
    localparam int S_LO  = 9;
    localparam int S_INP = 10;
    localparam int S_GPR = 16;

    logic        clk;
    logic        Reset, MD_Read, Gra, Grb, Grc, Rin, Rout, BAout;
    logic        WriteRAM, ReadRAM, Stop;
    logic [31:0] enable, busSelect, InPortData;
    logic [4:0]  Control_Signals;
    logic [31:0] ir;
    logic        CONFFOut;

    logic [63:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          n_compared;
    int          n_failed;

    cpu_datapath dut (
        .clk             (clk),
        .Reset           (Reset),
        .MD_Read         (MD_Read),
        .Gra             (Gra),
        .Grb             (Grb),
        .Grc             (Grc),
        .Rin             (Rin),
        .Rout            (Rout),
        .BAout           (BAout),
        .WriteRAM        (WriteRAM),
        .ReadRAM         (ReadRAM),
        .enable          (enable),
        .busSelect       (busSelect),
        .InPortData      (InPortData),
        .Control_Signals (Control_Signals),
        .ir              (ir),
        .CONFFOut        (CONFFOut),
        .Stop            (Stop)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] observe(input int sel);
        logic [3:0] ri;
        ri = 4'(sel - S_GPR);
        case (sel)
            S_BUS:   return {32'h0, dut.bus};
            S_IR:    return {32'h0, ir};
            S_CON:   return {63'h0, CONFFOut};
            S_PC:    return {32'h0, dut.pc};
            S_MAR:   return {32'h0, dut.mar};
            S_MDR:   return {32'h0, dut.mdr};
            S_Y:     return {32'h0, dut.y};
            S_Z:     return dut.z;
            S_HI:    return {32'h0, dut.hi};
            S_LO:    return {32'h0, dut.lo};
            S_INP:   return {32'h0, dut.in_port};
            default: return {32'h0, dut.gpr[ri]};
        endcase
    endfunction

    // Monitor: pop and compare everything queued during this cycle
    always @(negedge clk) begin
        logic [63:0] e_v;
        logic [63:0] a_v;
        int          s_v;
        string       n_v;
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            s_v = sel_q.pop_front();
            n_v = name_q.pop_front();
            a_v = observe(s_v);
            n_compared++;
            if (a_v !== e_v) begin
                n_failed++;
                $display("FAIL %s: got %h expected %h", n_v, a_v, e_v);
            end
        end
    end

    // Driver tasks
    task automatic clr();
        enable = '0; busSelect = '0; Control_Signals = '0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        WriteRAM = 0; ReadRAM = 0; MD_Read = 0; Stop = 0; Reset = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic expect_v(input string n, input int s, input logic [63:0] v);
        name_q.push_back(n);
        sel_q.push_back(s);
        exp_q.push_back(v);
    endtask

    task automatic inport(input logic [31:0] v);
        InPortData = v;
        enable[EN_INPORT] = 1'b1;
        tick();
    endtask

    task automatic from_inport(input logic [31:0] v, input int en_bit);
        inport(v);
        busSelect[BS_INPORT] = 1'b1;
        enable[en_bit] = 1'b1;
        tick();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] bval);
        inport(bval);
        busSelect[BS_INPORT] = 1'b1;
        enable[EN_Z] = 1'b1;
        Control_Signals = op;
        tick();
    endtask

    logic [4:0]  t_op [13];
    logic [31:0] t_b  [13];
    logic [63:0] t_z  [13];

    initial begin
        n_compared = 0;
        n_failed   = 0;
        InPortData = '0;
        clr();
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr();

        // Fill state with non-zero values and put 0x1234 into RAM[5]
        inport(32'h1234);
        busSelect[BS_INPORT] = 1'b1;
        enable[9:0] = '1;
        Gra = 1'b1; Rin = 1'b1;
        tick();
        expect_v("pre_pc", S_PC, 64'h1234);
        expect_v("pre_ir", S_IR, 64'h1234);
        expect_v("pre_r0", S_GPR + 0, 64'h1234);
        expect_v("pre_z", S_Z, 64'h1234);
        from_inport(32'd5, EN_MAR);
        WriteRAM = 1'b1;
        tick();

        // Reset wins over every strobe
        InPortData = 32'hFFFF_FFFF;
        Reset = 1'b1;
        enable = '1;
        busSelect[BS_INPORT] = 1'b1;
        Gra = 1'b1; Rin = 1'b1; Rout = 1'b1;
        tick();
        expect_v("rst_ir", S_IR, 64'h0);
        expect_v("rst_con", S_CON, 64'h0);
        expect_v("rst_pc", S_PC, 64'h0);
        expect_v("rst_mar", S_MAR, 64'h0);
        expect_v("rst_mdr", S_MDR, 64'h0);
        expect_v("rst_y", S_Y, 64'h0);
        expect_v("rst_z", S_Z, 64'h0);
        expect_v("rst_hi", S_HI, 64'h0);
        expect_v("rst_lo", S_LO, 64'h0);
        expect_v("rst_inport", S_INP, 64'h0);
        for (int i = 0; i < 16; i++) expect_v($sformatf("rst_r%0d", i), S_GPR + i, 64'h0);
        from_inport(32'd5, EN_MAR);
        ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDR] = 1'b1;
        tick();
        expect_v("ram5_kept", S_MDR, 64'h1234);

        // Load path into R1 and Y
        from_inport(32'd7, EN_MDR);
        expect_v("inport7", S_INP, 64'd7);
        expect_v("mdr7", S_MDR, 64'd7);
        from_inport(32'h0088_0000, EN_IR);
        expect_v("ir_load", S_IR, 64'h0088_0000);
        busSelect[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
        tick();
        expect_v("r1_7", S_GPR + 1, 64'd7);
        Gra = 1'b1; Rout = 1'b1; enable[EN_Y] = 1'b1;
        expect_v("bus_rout_r1", S_BUS, 64'd7);
        tick();
        expect_v("y7", S_Y, 64'd7);

        // ALU: ADD, then MUL with a negative operand
        alu_op(OP_ADD, 32'd5);
        expect_v("add", S_Z, 64'd12);
        busSelect[BS_ZLO] = 1'b1; enable[EN_MAR] = 1'b1;
        tick();
        expect_v("mar_zlo", S_MAR, 64'd12);
        from_inport(32'hFFFF_FFFD, EN_Y);
        alu_op(OP_MUL, 32'd4);
        expect_v("mul", S_Z, 64'hFFFF_FFFF_FFFF_FFF4);
        busSelect[BS_ZHI] = 1'b1; enable[EN_HI] = 1'b1;
        tick();
        busSelect[BS_ZLO] = 1'b1; enable[EN_LO] = 1'b1;
        tick();
        expect_v("hi", S_HI, 64'hFFFF_FFFF);
        expect_v("lo", S_LO, 64'hFFFF_FFF4);
        busSelect[BS_HI] = 1'b1; busSelect[BS_LO] = 1'b1;
        expect_v("bus_hi_over_lo", S_BUS, 64'hFFFF_FFFF);
        tick();

        // Remaining ops with Y = -3
        t_op = '{OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
                 OP_ROL, OP_NEG, OP_NOT, OP_INC, 5'd31, OP_SHL};
        t_b  = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4,
                 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'h21};
        t_z  = '{64'hFFFF_FFF9, 64'h4, 64'hFFFF_FFFD, 64'h0FFF_FFFF, 64'hFFFF_FFFF,
                 64'hFFFF_FFD0, 64'hDFFF_FFFF, 64'hFFFF_FFDF, 64'hFFFF_FFFC,
                 64'hFFFF_FFFB, 64'h5, 64'h4, 64'hFFFF_FFFA};
        for (int i = 0; i < 13; i++) begin
            alu_op(t_op[i], t_b[i]);
            expect_v($sformatf("alu_op%0d_b%0h", t_op[i], t_b[i]), S_Z, t_z[i]);
        end

        // Memory round trip and read-during-write
        from_inport(32'd3, EN_MAR);
        from_inport(32'hDEAD_BEEF, EN_MDR);
        WriteRAM = 1'b1;
        tick();
        enable[EN_MDR] = 1'b1;
        tick();
        expect_v("mdr_cleared", S_MDR, 64'h0);
        ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDR] = 1'b1;
        tick();
        expect_v("ram3_read", S_MDR, 64'hDEAD_BEEF);
        from_inport(32'h1111_1111, EN_MDR);
        WriteRAM = 1'b1; ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDR] = 1'b1;
        tick();
        expect_v("rw_same_old", S_MDR, 64'hDEAD_BEEF);
        ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDR] = 1'b1;
        tick();
        expect_v("rw_same_new", S_MDR, 64'h1111_1111);
        MD_Read = 1'b1; enable[EN_MDR] = 1'b1;
        tick();
        expect_v("ram_read_off", S_MDR, 64'h0);
        from_inport(32'hAAAA_5555, EN_MDR);
        WriteRAM = 1'b1; Stop = 1'b1;
        tick();
        ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDR] = 1'b1;
        tick();
        expect_v("stop_blocks_ram", S_MDR, 64'h1111_1111);

        // BAout on R0, and DIV by zero / signed DIV
        from_inport(32'h0, EN_IR);
        inport(32'd9);
        busSelect[BS_INPORT] = 1'b1; Gra = 1'b1; Rin = 1'b1;
        tick();
        expect_v("r0_9", S_GPR + 0, 64'd9);
        Gra = 1'b1; BAout = 1'b1;
        expect_v("baout_r0", S_BUS, 64'h0);
        tick();
        Gra = 1'b1; Rout = 1'b1;
        expect_v("rout_r0", S_BUS, 64'd9);
        tick();
        from_inport(32'd7, EN_Y);
        enable[EN_Z] = 1'b1; Control_Signals = OP_DIV;
        tick();
        expect_v("div_by_zero", S_Z, 64'h0000_0007_FFFF_FFFF);
        from_inport(32'hFFFF_FFF9, EN_Y);
        alu_op(OP_DIV, 32'd2);
        expect_v("div_signed", S_Z, 64'hFFFF_FFFF_FFFF_FFFD);

        // Cout, CON, Stop and Reset over Stop
        from_inport(32'h001C_0005, EN_IR);
        busSelect[BS_C] = 1'b1;
        expect_v("cout_sext", S_BUS, 64'hFFFC_0005);
        tick();
        from_inport(32'h8000_0000, EN_CON);
        expect_v("con_neg", S_CON, 64'h1);
        from_inport(32'h0, EN_CON);
        expect_v("con_zero", S_CON, 64'h0);
        inport(32'h40);
        busSelect[BS_INPORT] = 1'b1; enable[EN_PC] = 1'b1; Stop = 1'b1;
        tick();
        expect_v("pc_stop", S_PC, 64'h0);
        busSelect[BS_INPORT] = 1'b1; enable[EN_PC] = 1'b1;
        tick();
        expect_v("pc_load", S_PC, 64'h40);
        Reset = 1'b1; Stop = 1'b1;
        tick();
        expect_v("reset_over_stop", S_PC, 64'h0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_compared++;
            n_failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
